// File: rtl/card_dealer.sv
// card_dealer: deals cards from a 52-entry lookup ROM in pseudo-random order.
// A free-running 8-bit LFSR picks a starting deck position. Positions that are
// already dealt are skipped by linear probing, one position per cycle. A dealt
// mask and a cards-remaining count track the state of the deck.
// card_dealer_checker holds the protocol assertions and is instantiated by the
// environment.

module card_dealer #(
    parameter int DECK_SIZE = 52,
    parameter int LFSR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shuffle,
    input  logic [LFSR_W-1:0] seed,
    input  logic              deal_req,
    output logic              busy,
    output logic              deal_valid,
    output logic              deal_empty,
    output logic [6:0]        card,
    output logic [5:0]        card_addr,
    output logic [5:0]        cards_left,
    output logic [5:0]        lookup_addr,
    input  logic [6:0]        lookup_data
);

    localparam logic [5:0] DECK_N   = 6'(DECK_SIZE);
    localparam logic [5:0] LAST_IDX = 6'(DECK_SIZE - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEEK = 1'b1
    } state_t;

    // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Fold the low six LFSR bits into 0..51. Values 52..63 map onto 0..11.
    function automatic logic [5:0] fold_candidate(input logic [LFSR_W-1:0] s);
        logic [5:0] c;
        c = s[5:0];
        if (c >= DECK_N) begin
            return c - DECK_N;
        end else begin
            return c;
        end
    endfunction

    // Linear probe advance with wrap from the last deck position back to 0.
    function automatic logic [5:0] probe_step(input logic [5:0] p);
        if (p == LAST_IDX) begin
            return 6'd0;
        end else begin
            return p + 6'd1;
        end
    endfunction

    state_t                 state_q;
    logic [DECK_SIZE-1:0]   mask_q;
    logic [5:0]             left_q;
    logic [LFSR_W-1:0]      lfsr_q;
    logic [LFSR_W-1:0]      lfsr_d;
    logic [LFSR_W-1:0]      reload_d;
    logic [5:0]             cand_d;
    logic [5:0]             probe_q;
    logic                   busy_q;
    logic                   valid_q;
    logic                   empty_q;
    logic [6:0]             card_q;
    logic [5:0]             card_addr_q;

    // Next LFSR value, shuffle reload value (all-zero seed would lock up) and start candidate.
    always_comb begin
        lfsr_d   = lfsr_step(lfsr_q);
        cand_d   = fold_candidate(lfsr_q);
        reload_d = {{(LFSR_W-1){1'b0}}, 1'b1};
        if (seed != {LFSR_W{1'b0}}) begin
            reload_d = seed;
        end else begin
            reload_d = {{(LFSR_W-1){1'b0}}, 1'b1};
        end
    end

    // Dealing FSM: accept requests in IDLE, probe for a free slot in SEEK.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            left_q      <= DECK_N;
            lfsr_q      <= {{(LFSR_W-1){1'b0}}, 1'b1};
            probe_q     <= 6'd0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            empty_q     <= 1'b0;
            card_q      <= 7'd0;
            card_addr_q <= 6'd0;
        end else begin
            valid_q <= 1'b0;
            empty_q <= 1'b0;
            if (shuffle) begin
                // Shuffle wins over any request and abandons a deal in progress.
                lfsr_q  <= reload_d;
                mask_q  <= '0;
                left_q  <= DECK_N;
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                lfsr_q <= lfsr_d;
                case (state_q)
                    IDLE: begin
                        if (deal_req) begin
                            if (left_q == 6'd0) begin
                                empty_q <= 1'b1;
                            end else begin
                                probe_q <= cand_d;
                                state_q <= SEEK;
                                busy_q  <= 1'b1;
                            end
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    SEEK: begin
                        if (!mask_q[probe_q]) begin
                            card_q          <= lookup_data;
                            card_addr_q     <= probe_q;
                            mask_q[probe_q] <= 1'b1;
                            left_q          <= left_q - 6'd1;
                            valid_q         <= 1'b1;
                            state_q         <= IDLE;
                            busy_q          <= 1'b0;
                        end else begin
                            // A free slot is guaranteed while cards remain, so this terminates.
                            probe_q <= probe_step(probe_q);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The probe register doubles as the ROM address and holds its value in IDLE.
    assign lookup_addr = probe_q;
    assign busy        = busy_q;
    assign deal_valid  = valid_q;
    assign deal_empty  = empty_q;
    assign card        = card_q;
    assign card_addr   = card_addr_q;
    assign cards_left  = left_q;

endmodule

// Protocol assertions for card_dealer outputs.
module card_dealer_checker (
    input logic       clk,
    input logic       rst,
    input logic       busy,
    input logic       deal_valid,
    input logic       deal_empty,
    input logic [5:0] cards_left,
    input logic [5:0] lookup_addr
);

    // Check output invariants on every clock outside reset.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(deal_valid && deal_empty))
                else $error("deal_valid and deal_empty high together");
            assert (cards_left <= 6'd52)
                else $error("cards_left out of range: %0d", cards_left);
            assert (lookup_addr <= 6'd51)
                else $error("lookup_addr out of range: %0d", lookup_addr);
            assert (!(deal_valid && busy))
                else $error("deal_valid while busy");
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: a control-vector table, then a
// scoreboard-driven deal model (LFSR, mask, linear probing) for the multi-cycle cases.

module tb_card_dealer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       shuffle = 1'b0;
    logic [7:0] seed = 8'h00;
    logic       deal_req = 1'b0;
    logic       busy, deal_valid, deal_empty;
    logic [6:0] card;
    logic [5:0] card_addr, cards_left, lookup_addr;
    logic [6:0] lookup_data;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [7:0]  m_lfsr = 8'h01;
    logic [51:0] m_mask = '0;
    int          m_left = 52;
    logic [51:0] seen;

    typedef struct {
        logic       empty;
        logic [5:0] addr;
        logic [6:0] card;
        int         lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic       rst;
        logic       shuffle;
        logic [7:0] seed;
        logic       req;
        logic       busy;
        logic [5:0] left;
        logic       valid;
        logic       empty;
    } vec_t;
    vec_t vec[10];

    always #5 clk = ~clk;

    // Card ROM: bits [5:4] suit, bits [3:0] rank (ace=11, faces=10).
    function automatic logic [6:0] rom_word(input logic [5:0] a);
        int s, i;
        logic [3:0] r;
        logic [1:0] s2;
        s = int'(a) / 13;
        i = int'(a) % 13;
        if (i == 0) r = 4'd11;
        else if (i <= 9) r = 4'(i + 1);
        else r = 4'd10;
        s2 = 2'(s);
        return {1'b0, s2, r};
    endfunction

    assign lookup_data = rom_word(lookup_addr);

    card_dealer #(.DECK_SIZE(52), .LFSR_W(8)) dut (
        .clk(clk), .rst(rst), .shuffle(shuffle), .seed(seed), .deal_req(deal_req),
        .busy(busy), .deal_valid(deal_valid), .deal_empty(deal_empty),
        .card(card), .card_addr(card_addr), .cards_left(cards_left),
        .lookup_addr(lookup_addr), .lookup_data(lookup_data)
    );

    card_dealer_checker chk_u (
        .clk(clk), .rst(rst), .busy(busy), .deal_valid(deal_valid),
        .deal_empty(deal_empty), .cards_left(cards_left), .lookup_addr(lookup_addr)
    );

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [5:0] cand(input logic [7:0] s);
        logic [5:0] c;
        c = s[5:0];
        if (c >= 6'd52) c = c - 6'd52;
        return c;
    endfunction

    // Predict the dealt address and number of skipped slots from a start state.
    function automatic void predict(input logic [7:0] l, input logic [51:0] m,
                                    output logic [5:0] a, output int k);
        logic [5:0] p;
        p = cand(l);
        k = 0;
        for (int n = 0; n < 52; n++) begin
            if (!m[p]) break;
            p = (p == 6'd51) ? 6'd0 : p + 6'd1;
            k++;
        end
        a = p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: model follows the inputs sampled at the edge; outputs read at negedge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_lfsr = 8'h01; m_mask = '0; m_left = 52;
        end else if (shuffle) begin
            m_lfsr = (seed == 8'h00) ? 8'h01 : seed; m_mask = '0; m_left = 52;
        end else begin
            m_lfsr = lfsr_step(m_lfsr);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    // Issue one request, push the expected result, wait for the response and compare.
    task automatic do_deal();
        exp_t e;
        int lat, k;
        logic [5:0] a;
        if (m_left == 0) begin
            e.empty = 1'b1; e.addr = 6'd0; e.card = 7'd0; e.lat = 1;
        end else begin
            predict(m_lfsr, m_mask, a, k);
            e.empty = 1'b0; e.addr = a; e.card = rom_word(a); e.lat = 2 + k;
            m_mask[a] = 1'b1;
            m_left--;
        end
        sb.push_back(e);
        deal_req = 1'b1; tick(); deal_req = 1'b0;
        lat = 1;
        while (!deal_valid && !deal_empty && lat < 64) begin
            tick(); lat++;
        end
        e = sb.pop_front();
        if (e.empty) begin
            chk("empty_pulse", deal_empty, 1);
            chk("empty_no_valid", deal_valid, 0);
            chk("empty_latency", lat, 1);
            chk("empty_left", cards_left, 0);
        end else begin
            chk("deal_valid", deal_valid, 1);
            chk("deal_latency", lat, e.lat);
            chk("card_addr", card_addr, e.addr);
            chk("card", card, e.card);
            chk("cards_left", cards_left, m_left);
            seen[card_addr] = 1'b1;
        end
        tick();
        chk("pulse_one_cycle", deal_valid | deal_empty, 0);
    endtask

    initial begin
        logic [5:0] a;
        int k, cnt;

        // rst shuffle seed req | busy left valid empty
        vec[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 6'd52, 1'b0, 1'b0};
        vec[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'd52, 1'b0, 1'b0};
        vec[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 6'd52, 1'b0, 1'b0};
        vec[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'd51, 1'b1, 1'b0};
        vec[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'd51, 1'b0, 1'b0};
        vec[5] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 6'd52, 1'b0, 1'b0};
        vec[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 6'd52, 1'b0, 1'b0};
        vec[7] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 6'd52, 1'b0, 1'b0};
        vec[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'd52, 1'b0, 1'b0};
        vec[9] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 6'd52, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            rst = vec[i].rst; shuffle = vec[i].shuffle; seed = vec[i].seed; deal_req = vec[i].req;
            tick();
            chk($sformatf("vec%0d_busy", i), busy, vec[i].busy);
            chk($sformatf("vec%0d_left", i), cards_left, vec[i].left);
            chk($sformatf("vec%0d_valid", i), deal_valid, vec[i].valid);
            chk($sformatf("vec%0d_empty", i), deal_empty, vec[i].empty);
        end
        rst = 1'b0; shuffle = 1'b0; seed = 8'h00; deal_req = 1'b0;
        chk("reset_card", card, 0);
        chk("reset_card_addr", card_addr, 0);
        chk("reset_lookup_addr", lookup_addr, 0);

        // First deal after reset.
        do_deal();

        // Full deck, then a request on the empty deck.
        do_reset();
        seen = '0;
        for (int i = 0; i < 52; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            do_deal();
        end
        chk("full_deck_distinct", seen, {52{1'b1}});
        chk("full_deck_left", cards_left, 0);
        do_deal();
        tick();
        chk("empty_left_hold", cards_left, 0);

        // Probe wrap: leave only address 0 free, then deal it.
        do_reset();
        for (int i = 0; i < 51; i++) begin
            for (int w = 0; w < 300; w++) begin
                predict(m_lfsr, m_mask, a, k);
                if (a != 6'd0) break;
                tick();
            end
            do_deal();
        end
        for (int w = 0; w < 300; w++) begin
            if (cand(m_lfsr) > 6'd20) break;
            tick();
        end
        do_deal();
        chk("wrap_addr", card_addr, 0);
        chk("wrap_card", card, 7'h0B);

        // Shuffle while seeking aborts the deal.
        do_reset();
        for (int i = 0; i < 10; i++) do_deal();
        deal_req = 1'b1; tick(); deal_req = 1'b0;
        chk("seek_busy", busy, 1);
        shuffle = 1'b1; seed = 8'hA5; tick(); shuffle = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_no_valid", deal_valid, 0);
        chk("abort_left", cards_left, 52);
        tick();
        chk("abort_no_late_valid", deal_valid, 0);
        seen = '0;
        for (int i = 0; i < 52; i++) do_deal();
        chk("reshuffle_distinct", seen, {52{1'b1}});

        // Shuffle with zero seed beats a same-cycle request.
        shuffle = 1'b1; seed = 8'h00; deal_req = 1'b1; tick();
        shuffle = 1'b0; deal_req = 1'b0;
        chk("zseed_busy", busy, 0);
        chk("zseed_left", cards_left, 52);
        do_deal();
        chk("zseed_first_addr", card_addr, 1);

        // A request while busy is ignored.
        deal_req = 1'b1; tick();
        chk("busy_req_busy", busy, 1);
        tick(); deal_req = 1'b0;
        cnt = deal_valid ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            cnt += deal_valid ? 1 : 0;
        end
        chk("busy_req_one_valid", cnt, 1);

        // Reset in the middle of a seek with 30 cards left.
        do_reset();
        for (int i = 0; i < 22; i++) do_deal();
        chk("pre_rst_left", cards_left, 30);
        deal_req = 1'b1; tick(); deal_req = 1'b0;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_left", cards_left, 52);
        chk("rst_busy", busy, 0);
        chk("rst_card", card, 0);
        chk("rst_no_valid", deal_valid, 0);
        tick();
        chk("rst_no_late_valid", deal_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
